proc_core_param: RTL and testbench

//  Parametrised multi-cycle processor core; merges control FSM, register file and ALU behind

---
 rtl/proc_core_param_if.sv | 27 ++
 rtl/proc_core_param.sv | 187 ++++++++++++++++++
 tb/tb_proc_core_param.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_core_param_if.sv
// Memory-side bus of proc_core_param: instruction fetch port and data access port,
// each a level request held stable until the memory returns a one-cycle ack.
interface proc_core_param_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [7:0]        dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/proc_core_param.sv
// Parametrised multi-cycle core: FSM, register file and ALU behind valid/ack memory ports.
// Optional build macro PROC_ILLEGAL_TRAP_EN: illegal opcodes trap to ERROR instead of acting as NOOP.
module proc_core_param #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8,
  parameter int NREG   = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  proc_core_param_if.master    bus,
  output logic                 halted,
  output logic [15:0]          IR_Out,
  output logic [PC_W-1:0]      PC_Out,
  output logic [3:0]           StateO,
  output logic [DATA_W-1:0]    ALU_Out,
  output logic [DATA_W-1:0]    RQ0
);

  localparam int RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;
  localparam logic [3:0] OP_JZ    = 4'h6;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM    = 4'd4,
    S_HALT   = 4'd5,
    S_ERROR  = 4'd6
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic                imem_req_q, imem_req_d;
  logic                dmem_req_q, dmem_req_d;
  logic                dmem_we_q, dmem_we_d;
  logic [7:0]          dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic                halted_q, halted_d;

  logic [DATA_W-1:0]   rf_q [NREG];
  logic                rf_we;
  logic [RIDX_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;

  logic [3:0]          op;
  logic [RIDX_W-1:0]   ra, rb, rd;
  logic [DATA_W-1:0]   rf_a, rf_b, alu_res;

  function automatic logic [DATA_W-1:0] alu_f(input logic [3:0] opc,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    case (opc)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      default: return a;
    endcase
  endfunction

  assign op      = ir_q[15:12];
  assign ra      = ir_q[8 +: RIDX_W];
  assign rb      = ir_q[4 +: RIDX_W];
  assign rd      = ir_q[0 +: RIDX_W];
  assign rf_a    = rf_q[ra];
  assign rf_b    = rf_q[rb];
  assign alu_res = alu_f(op, rf_a, rf_b);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    rf_we        = 1'b0;
    rf_waddr     = rd;
    rf_wdata     = alu_res;

    unique case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OP_NOOP: state_d = S_FETCH;
          OP_STORE, OP_LOAD: begin
            // Access qualifiers are latched here so they stay stable across wait states.
            dmem_we_d    = (op == OP_STORE);
            dmem_addr_d  = ir_q[7:0];
            dmem_wdata_d = rf_a;
            state_d      = S_MEM;
          end
          OP_ADD, OP_SUB, OP_JZ: state_d = S_EXEC;
          OP_HALT: state_d = S_HALT;
          default: begin
`ifdef PROC_ILLEGAL_TRAP_EN
            state_d = S_ERROR;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_EXEC: begin
        if (op == OP_ADD || op == OP_SUB) begin
          rf_we = 1'b1;
        end else if (op == OP_JZ && rf_a == '0) begin
          pc_d = PC_W'(ir_q[7:0]);
        end
        state_d = S_FETCH;
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          if (!dmem_we_q) begin
            rf_we    = 1'b1;
            rf_waddr = ra;
            rf_wdata = bus.dmem_rdata;
          end
          dmem_we_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_HALT, S_ERROR: state_d = state_q;
      default: state_d = S_INIT;
    endcase

    // Request/status outputs are registered from the state being entered.
    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
    halted_d   = (state_d == S_HALT) || (state_d == S_ERROR);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_INIT;
      pc_q       <= '0;
      ir_q       <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      halted_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      halted_q   <= halted_d;
      if (rf_we) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    dmem_addr_q  <= dmem_addr_d;
    dmem_wdata_q <= dmem_wdata_d;
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;

  assign halted  = halted_q;
  assign IR_Out  = ir_q;
  assign PC_Out  = pc_q;
  assign StateO  = state_q;
  assign ALU_Out = alu_res;
  assign RQ0     = rf_q[0];

endmodule

// File: tb/tb_proc_core_param.sv
// Testbench for proc_core_param: memory responders with programmable wait states and an
// instruction-level reference interpreter for randomized programs.
module tb_proc_core_param;
  localparam int DATA_W = 16;
  localparam int PC_W   = 8;
  localparam int NREG   = 16;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              halted;
  logic [15:0]       IR_Out;
  logic [PC_W-1:0]   PC_Out;
  logic [3:0]        StateO;
  logic [DATA_W-1:0] ALU_Out;
  logic [DATA_W-1:0] RQ0;

  proc_core_param_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  proc_core_param #(.DATA_W(DATA_W), .PC_W(PC_W), .NREG(NREG)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus), .halted(halted), .IR_Out(IR_Out),
    .PC_Out(PC_Out), .StateO(StateO), .ALU_Out(ALU_Out), .RQ0(RQ0)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [15:0]       imem [256];
  logic [DATA_W-1:0] dmem [256];
  int                iwait_mode = 0;
  int                dwait_mode = 0;
  logic [PC_W-1:0]   fetch_q [$];
  logic [7:0]        st_addr_q [$];
  logic [DATA_W-1:0] st_data_q [$];

  // Reference model results
  int                exp_state;
  int                exp_pc;
  int                exp_fetches;
  logic [DATA_W-1:0] exp_r0;
  logic [7:0]        exp_sa [$];
  logic [DATA_W-1:0] exp_sd [$];

  // Memory responders: ack after a (possibly random) number of wait cycles.
  initial begin
    int ibusy, icnt, icur, dbusy, dcnt, dcur;
    ibusy = 0; icnt = 0; icur = 0; dbusy = 0; dcnt = 0; dcur = 0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    forever begin
      @(negedge Clk);
      if (!Reset || !bus.imem_req) begin
        bus.imem_ack = 1'b0; ibusy = 0;
      end else begin
        if (ibusy == 0) begin
          ibusy = 1; icnt = 0;
          icur = (iwait_mode < 0) ? int'($urandom_range(0, 3)) : iwait_mode;
        end
        if (icnt >= icur) begin
          bus.imem_ack = 1'b1; bus.imem_rdata = imem[bus.imem_addr];
          fetch_q.push_back(bus.imem_addr); ibusy = 0;
        end else begin
          bus.imem_ack = 1'b0; bus.imem_rdata = 16'($urandom); icnt++;
        end
      end
      if (!Reset || !bus.dmem_req) begin
        bus.dmem_ack = 1'b0; dbusy = 0;
      end else begin
        if (dbusy == 0) begin
          dbusy = 1; dcnt = 0;
          dcur = (dwait_mode < 0) ? int'($urandom_range(0, 3)) : dwait_mode;
        end
        if (dcnt >= dcur) begin
          bus.dmem_ack = 1'b1; dbusy = 0;
          if (bus.dmem_we) begin
            dmem[bus.dmem_addr] = bus.dmem_wdata;
            st_addr_q.push_back(bus.dmem_addr);
            st_data_q.push_back(bus.dmem_wdata);
          end else begin
            bus.dmem_rdata = dmem[bus.dmem_addr];
          end
        end else begin
          bus.dmem_ack = 1'b0; bus.dmem_rdata = DATA_W'($urandom); dcnt++;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic start_cpu();
    Reset = 1'b0;
    fetch_q.delete(); st_addr_q.delete(); st_data_q.delete();
    repeat (2) step();
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic run_to_halt(input int budget, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      step(); cycles++;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'h0000;
      dmem[i] = DATA_W'($urandom);
    end
  endtask

  // Instruction-level interpreter of the ISA.
  task automatic ref_model();
    logic [DATA_W-1:0] r [NREG];
    logic [DATA_W-1:0] m [256];
    logic [15:0] w;
    int pc, steps, a, b, d;
    bit done;
    for (int i = 0; i < NREG; i++) r[i] = '0;
    for (int i = 0; i < 256; i++) m[i] = dmem[i];
    exp_sa.delete(); exp_sd.delete();
    pc = 0; steps = 0; done = 0; exp_state = 1;
    while (!done && steps < 2000) begin
      w = imem[pc];
      pc = (pc + 1) % (1 << PC_W);
      steps++;
      a = int'(w[11:8]) % NREG; b = int'(w[7:4]) % NREG; d = int'(w[3:0]) % NREG;
      case (w[15:12])
        4'h0: ;
        4'h1: begin exp_sa.push_back(w[7:0]); exp_sd.push_back(r[a]); m[w[7:0]] = r[a]; end
        4'h2: r[a] = m[w[7:0]];
        4'h3: r[d] = r[a] + r[b];
        4'h4: r[d] = r[a] - r[b];
        4'h5: begin exp_state = 5; done = 1; end
        4'h6: if (r[a] == 0) pc = int'(w[7:0]) % (1 << PC_W);
        default: begin
`ifdef PROC_ILLEGAL_TRAP_EN
          exp_state = 6; done = 1;
`endif
        end
      endcase
    end
    exp_pc = pc; exp_fetches = steps; exp_r0 = r[0];
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] v;
    int n;
    clear_mem();
    v = DATA_W'($urandom) | DATA_W'(1);
    dmem[8'h10] = v;
    imem[0] = 16'h2010; imem[1] = 16'h5000;
    iwait_mode = 3; dwait_mode = 0;
    start_cpu();
    n = 0;
    while (!(StateO == 4'd1 && RQ0 != '0) && n < 60) begin step(); n++; end
    checks++; if (RQ0 !== v) begin errors++; $display("FAIL reset_preload R0 got %h want %h", RQ0, v); end
    step();
    #2 Reset = 1'b0;
    #1;
    checks++; if (StateO !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", StateO); end
    checks++; if (PC_Out !== '0) begin errors++; $display("FAIL reset_pc got %h want 0", PC_Out); end
    checks++; if (IR_Out !== 16'h0) begin errors++; $display("FAIL reset_ir got %h want 0", IR_Out); end
    checks++; if (RQ0 !== '0) begin errors++; $display("FAIL reset_rq0 got %h want 0", RQ0); end
    checks++; if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL reset_outputs imem_req=%b dmem_req=%b halted=%b want 000", bus.imem_req, bus.dmem_req, halted);
    end
    @(negedge Clk) Reset = 1'b1;
    step();
    checks++; if (StateO !== 4'd1 || bus.imem_addr !== '0) begin
      errors++; $display("FAIL reset_exit state=%0d addr=%h want 1/00", StateO, bus.imem_addr);
    end
  endtask

  task automatic test_program();
    int n;
    clear_mem();
    imem[0] = 16'h2010; imem[1] = 16'h2111; imem[2] = 16'h3012; imem[3] = 16'h1220; imem[4] = 16'h5000;
    dmem[8'h10] = DATA_W'(5); dmem[8'h11] = DATA_W'(3);
    iwait_mode = 0; dwait_mode = 0;
    start_cpu();
    step();
    checks++; if (StateO !== 4'd1) begin errors++; $display("FAIL prog_init_exit state=%0d want 1", StateO); end
    n = 0;
    while (StateO != 4'd5 && n < 100) begin step(); n++; end
    checks++; if (n != 14) begin errors++; $display("FAIL prog_cycles got %0d want 14", n); end
    checks++; if (halted !== 1'b1 || PC_Out !== 8'd5) begin
      errors++; $display("FAIL prog_halt halted=%b pc=%h want 1/05", halted, PC_Out);
    end
    checks++; if (RQ0 !== DATA_W'(5)) begin errors++; $display("FAIL prog_r0 got %h want 5", RQ0); end
    checks++;
    if (st_addr_q.size() != 1 || st_addr_q[0] !== 8'h20 || st_data_q[0] !== DATA_W'(8)) begin
      errors++; $display("FAIL prog_store count=%0d want one store of 8 at 0x20", st_addr_q.size());
    end
  endtask

  task automatic test_wait_states();
    logic [DATA_W-1:0] v;
    int fcnt, mcnt, bad, n;
    clear_mem();
    v = DATA_W'($urandom) | DATA_W'(1);
    dmem[8'h10] = v;
    imem[0] = 16'h2010; imem[1] = 16'h1030; imem[2] = 16'h5000;
    iwait_mode = 3; dwait_mode = 3;
    start_cpu();
    step();
    fcnt = 0; bad = 0;
    while (StateO == 4'd1 && fcnt < 20) begin
      if (bus.imem_addr !== 8'h00 || PC_Out !== 8'h00 || IR_Out !== 16'h0 || bus.imem_req !== 1'b1) bad++;
      fcnt++; step();
    end
    checks++; if (fcnt != 4 || bad != 0) begin errors++; $display("FAIL wait_fetch cycles=%0d unstable=%0d want 4/0", fcnt, bad); end
    checks++; if (IR_Out !== 16'h2010 || PC_Out !== 8'h01 || StateO !== 4'd2) begin
      errors++; $display("FAIL wait_fetch_done ir=%h pc=%h st=%0d want 2010/01/2", IR_Out, PC_Out, StateO);
    end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (StateO != 4'd4 && n < 40) begin step(); n++; end
      mcnt = 0; bad = 0;
      while (StateO == 4'd4 && mcnt < 20) begin
        if (bus.dmem_req !== 1'b1 || bus.dmem_we !== (k == 1) || bus.dmem_addr !== (k == 1 ? 8'h30 : 8'h10)) bad++;
        if (k == 1 && bus.dmem_wdata !== v) bad++;
        if (k == 0 && RQ0 !== '0) bad++;
        mcnt++; step();
      end
      checks++; if (mcnt != 4 || bad != 0) begin errors++; $display("FAIL wait_mem%0d cycles=%0d unstable=%0d want 4/0", k, mcnt, bad); end
    end
    checks++; if (RQ0 !== v) begin errors++; $display("FAIL wait_load got %h want %h", RQ0, v); end
    checks++; if (st_addr_q.size() != 1 || st_data_q[0] !== v) begin
      errors++; $display("FAIL wait_store count=%0d want 1 store of %h", st_addr_q.size(), v);
    end
  endtask

  task automatic test_alu_jz();
    logic [PC_W-1:0] exp_tr [$];
    logic [DATA_W-1:0] alu_add;
    bit seen;
    int n;
    clear_mem();
    imem[0] = 16'h2010; imem[1] = 16'h2111; imem[2] = 16'h3012; imem[3] = 16'h1220; imem[4] = 16'h6220;
    imem[8'h20] = 16'h6100; imem[8'h21] = 16'h5000;
    dmem[8'h10] = 16'hFFFF; dmem[8'h11] = 16'h0001;
    iwait_mode = -1; dwait_mode = -1;
    start_cpu();
    seen = 0; alu_add = '1; n = 0;
    while (!halted && n < 400) begin
      step(); n++;
      if (StateO == 4'd3 && IR_Out == 16'h3012) begin seen = 1; alu_add = ALU_Out; end
    end
    checks++; if (!seen || alu_add !== '0) begin errors++; $display("FAIL alu_add_wrap seen=%0d got %h want 0000", seen, alu_add); end
    checks++; if (st_data_q.size() != 1 || st_data_q[0] !== '0) begin
      errors++; $display("FAIL alu_r2_store count=%0d want one store of 0000", st_data_q.size());
    end
    exp_tr = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h20, 8'h21};
    checks++; if (fetch_q != exp_tr) begin
      errors++; $display("FAIL jz_trace fetches=%0d want 7 (0..4,20,21)", fetch_q.size());
    end
    checks++; if (StateO !== 4'd5 || PC_Out !== 8'h22) begin
      errors++; $display("FAIL jz_end state=%0d pc=%h want 5/22", StateO, PC_Out);
    end
  endtask

  task automatic test_pc_wrap();
    int n;
    clear_mem();
    iwait_mode = 0; dwait_mode = 0;
    start_cpu();
    n = 0;
    while (!(StateO == 4'd1 && bus.imem_addr == 8'hFF) && n < 1000) begin step(); n++; end
    step();
    checks++; if (StateO !== 4'd2 || PC_Out !== 8'h00) begin
      errors++; $display("FAIL pc_wrap st=%0d pc=%h want 2/00", StateO, PC_Out);
    end
    step();
    checks++; if (StateO !== 4'd1 || bus.imem_addr !== 8'h00) begin
      errors++; $display("FAIL pc_wrap_fetch st=%0d addr=%h want 1/00", StateO, bus.imem_addr);
    end
  endtask

  task automatic test_illegal();
    int n;
    clear_mem();
    imem[0] = 16'h7000;
    imem[1] = {4'($urandom_range(7, 15)), 12'($urandom)};
    imem[2] = 16'h5000;
    iwait_mode = -1; dwait_mode = -1;
    start_cpu();
    run_to_halt(200, n);
`ifdef PROC_ILLEGAL_TRAP_EN
    checks++; if (halted !== 1'b1 || StateO !== 4'd6 || PC_Out !== 8'h01) begin
      errors++; $display("FAIL illegal_trap halted=%b st=%0d pc=%h want 1/6/01", halted, StateO, PC_Out);
    end
    step();
    checks++; if (StateO !== 4'd6 || bus.imem_req !== 1'b0 || fetch_q.size() != 1) begin
      errors++; $display("FAIL illegal_hold st=%0d req=%b fetches=%0d want 6/0/1", StateO, bus.imem_req, fetch_q.size());
    end
`else
    checks++; if (halted !== 1'b1 || StateO !== 4'd5 || PC_Out !== 8'h03) begin
      errors++; $display("FAIL illegal_noop halted=%b st=%0d pc=%h want 1/5/03", halted, StateO, PC_Out);
    end
    checks++; if (fetch_q.size() != 3 || st_addr_q.size() != 0) begin
      errors++; $display("FAIL illegal_noop_trace fetches=%0d stores=%0d want 3/0", fetch_q.size(), st_addr_q.size());
    end
`endif
  endtask

  task automatic test_random();
    int len, n, sel, tgt;
    for (int it = 0; it < 25; it++) begin
      clear_mem();
      len = $urandom_range(4, 20);
      for (int i = 0; i < len; i++) begin
        sel = $urandom_range(0, 11);
        case (sel)
          0:        imem[i] = {4'h0, 12'($urandom)};
          1, 2:     imem[i] = {4'h1, 12'($urandom)};
          3, 4:     imem[i] = {4'h2, 12'($urandom)};
          5, 6, 11: imem[i] = {4'h3, 12'($urandom)};
          7, 8:     imem[i] = {4'h4, 12'($urandom)};
          9: begin
            tgt = $urandom_range(i + 1, len);
            imem[i] = {4'h6, 4'($urandom), 8'(tgt)};
          end
          default:  imem[i] = {4'($urandom_range(7, 15)), 12'($urandom)};
        endcase
      end
      for (int r = 0; r < 16; r++) imem[len + r] = {4'h1, 4'(r), 8'(8'hF0 + r)};
      imem[len + 16] = 16'h5000;
      ref_model();
      iwait_mode = -1; dwait_mode = -1;
      start_cpu();
      run_to_halt(5000, n);
      checks++; if (halted !== 1'b1 || int'(StateO) != exp_state) begin
        errors++; $display("FAIL rand%0d_end halted=%b st=%0d want 1/%0d", it, halted, StateO, exp_state);
      end
      checks++; if (int'(PC_Out) != exp_pc || RQ0 !== exp_r0) begin
        errors++; $display("FAIL rand%0d_arch pc=%h r0=%h want %h/%h", it, PC_Out, RQ0, exp_pc, exp_r0);
      end
      checks++; if (fetch_q.size() != exp_fetches || st_addr_q.size() != exp_sa.size()) begin
        errors++; $display("FAIL rand%0d_counts fetches=%0d stores=%0d want %0d/%0d", it, fetch_q.size(), st_addr_q.size(), exp_fetches, exp_sa.size());
      end else begin
        for (int s = 0; s < exp_sa.size(); s++) begin
          checks++; if (st_addr_q[s] !== exp_sa[s] || st_data_q[s] !== exp_sd[s]) begin
            errors++; $display("FAIL rand%0d_store%0d got %h@%h want %h@%h", it, s, st_data_q[s], st_addr_q[s], exp_sd[s], exp_sa[s]);
          end
        end
      end
    end
  endtask

  initial begin
    Reset = 1'b0;
    clear_mem();
    test_reset();
    test_program();
    test_wait_states();
    test_alu_jz();
    test_pc_wrap();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
